// File: rtl/image_op_scheduler_pkg.sv
// Shared definitions for the image op scheduler: FSM encoding, command width and field offsets.
// Requesters and benches import this to pack commands the same way the scheduler unpacks them.
package image_op_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int OpcodeW = 3;

    // Command slot layout, MSB first: {opcode[2:0], invertX, invertY, translateX, translateY}
    function automatic int cmd_width(int w, int h);
        return 5 + w + h;
    endfunction

    function automatic int translate_x_lsb(int h);
        return h;
    endfunction

    function automatic int invert_y_bit(int w, int h);
        return w + h;
    endfunction

    function automatic int invert_x_bit(int w, int h);
        return w + h + 1;
    endfunction

    function automatic int opcode_lsb(int w, int h);
        return w + h + 2;
    endfunction

endpackage

// File: rtl/image_op_scheduler_if.sv
// Requester and processor signals of the image op scheduler.
// slave is the scheduler side; master is the requester/processor side.
interface image_op_scheduler_if #(
    parameter int NumRequesters     = 4,
    parameter int WidthAddressSize  = 8,
    parameter int HeightAddressSize = 8
);
    import image_op_scheduler_pkg::*;

    localparam int CmdW = cmd_width(WidthAddressSize, HeightAddressSize);

    logic [NumRequesters-1:0]      req;
    logic [NumRequesters*CmdW-1:0] cmd;
    logic [NumRequesters-1:0]      gnt;
    logic [NumRequesters-1:0]      done;
    logic                          proc_ce;
    logic [OpcodeW-1:0]            proc_opcode;
    logic                          proc_invertX;
    logic                          proc_invertY;
    logic [WidthAddressSize-1:0]   proc_translateX;
    logic [HeightAddressSize-1:0]  proc_translateY;
    logic                          proc_busy;

    modport master (
        output req, cmd, proc_busy,
        input  gnt, done, proc_ce, proc_opcode, proc_invertX, proc_invertY,
               proc_translateX, proc_translateY
    );

    modport slave (
        input  req, cmd, proc_busy,
        output gnt, done, proc_ce, proc_opcode, proc_invertX, proc_invertY,
               proc_translateX, proc_translateY
    );

endinterface

// File: rtl/image_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from (last+1) mod N and returns
// a one-hot grant plus its index. With no request the index echoes last.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    logic found;
    int   cand;

    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[IdxW'(cand)]) begin
                found                  = 1'b1;
                grant[IdxW'(cand)]     = 1'b1;
                grant_idx              = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/image_op_scheduler.sv
// Shares one image processor among NumRequesters command sources: round-robin grant,
// latched command drives the processor config, proc_ce handshake against proc_busy.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | proc_ce low; grant next requester and latch its command
// ST_ISSUE | proc_ce high; waiting for the processor to raise busy
// ST_RUN   | proc_ce high; waiting for busy to fall, then drop proc_ce
// ST_DONE  | proc_ce low; done pulse for owner, frame_count updated
module image_op_scheduler
    import image_op_scheduler_pkg::*;
#(
    parameter  int NumRequesters     = 4,
    parameter  int WidthAddressSize  = 8,
    parameter  int HeightAddressSize = 8,
    localparam int IdxW              = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    image_op_scheduler_if.slave   bus,
    output logic [IdxW-1:0]       owner,
    output logic [15:0]           frame_count
);

    localparam int CmdW   = cmd_width(WidthAddressSize, HeightAddressSize);
    localparam int TxLsb  = translate_x_lsb(HeightAddressSize);
    localparam int InvYB  = invert_y_bit(WidthAddressSize, HeightAddressSize);
    localparam int InvXB  = invert_x_bit(WidthAddressSize, HeightAddressSize);
    localparam int OpLsb  = opcode_lsb(WidthAddressSize, HeightAddressSize);

    sched_state_t             state;
    logic [CmdW-1:0]          cmd_reg;
    logic [CmdW-1:0]          slot_cmd;
    logic [NumRequesters-1:0] arb_grant;
    logic [IdxW-1:0]          arb_idx;
    logic [NumRequesters-1:0] gnt_q;
    logic [NumRequesters-1:0] done_q;
    logic                     ce_q;

    rr_arbiter #(.N(NumRequesters)) u_arb (
        .req       (bus.req),
        .last      (owner),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        slot_cmd = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (arb_grant[i]) slot_cmd = bus.cmd[i*CmdW +: CmdW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_reg     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            ce_q        <= 1'b0;
            frame_count <= '0;
            owner       <= IdxW'(NumRequesters - 1);
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q   <= arb_grant;
                        owner   <= arb_idx;
                        cmd_reg <= slot_cmd;
                        ce_q    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.proc_busy) state <= ST_RUN;
                end
                ST_RUN: begin
                    // Drop enable on the same edge busy is seen low so the processor cannot relaunch.
                    if (!bus.proc_busy) begin
                        ce_q        <= 1'b0;
                        done_q      <= NumRequesters'(1) << owner;
                        frame_count <= frame_count + 16'd1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.done            = done_q;
    assign bus.proc_ce         = ce_q;
    assign bus.proc_opcode     = cmd_reg[OpLsb +: OpcodeW];
    assign bus.proc_invertX    = cmd_reg[InvXB];
    assign bus.proc_invertY    = cmd_reg[InvYB];
    assign bus.proc_translateX = cmd_reg[TxLsb +: WidthAddressSize];
    assign bus.proc_translateY = cmd_reg[HeightAddressSize-1:0];

endmodule

// File: doc/image_op_scheduler.md
IMAGE_OP_SCHEDULER -- requirements
Module: image_op_scheduler

Interface
REQ-001 SHALL have parameter NumRequesters, default 4: number of command sources sharing one image processor.
REQ-002 SHALL have parameter WidthAddressSize, default 8: processor column address width.
REQ-003 SHALL have parameter HeightAddressSize, default 8: processor line address width.
REQ-004 SHALL have port clk  input  1: rising-edge clock.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NumRequesters: per-requester command valid, level.
REQ-007 SHALL have port cmd  input  NumRequesters*CmdW: per-requester command, CmdW = 5+W+H; slot i layout {opcode[2:0], invertX, invertY, translateX, translateY}.
REQ-008 SHALL have port gnt  output  NumRequesters: one-hot, 1-cycle pulse when a command is latched.
REQ-009 SHALL have port done  output  NumRequesters: one-hot, 1-cycle pulse when that requester's frame completes.
REQ-010 SHALL have port proc_ce  output  1: processor enable.
REQ-011 SHALL have ports proc_opcode(3), proc_invertX(1), proc_invertY(1), proc_translateX(W), proc_translateY(H)  output: processor configuration.
REQ-012 SHALL have port proc_busy  input  1: processor busy flag, which changes on the falling clock edge.
REQ-013 SHALL have port owner  output  clog2(NumRequesters): index of the current or last granted requester.
REQ-014 SHALL have port frame_count  output  16: completed frames, wraps from 0xFFFF to 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE, RUN, DONE.
REQ-016 IDLE: if any req is high, SHALL grant by round-robin starting at (last owner+1) mod N, latch that slot's cmd, pulse gnt, and go to ISSUE.
REQ-017 ISSUE: SHALL drive proc_ce=1; on the first rising edge with proc_busy=1, SHALL go to RUN.
REQ-018 RUN: SHALL hold proc_ce=1; on the first rising edge with proc_busy=0, SHALL drop proc_ce in that same edge and go to DONE.
REQ-019 DONE: SHALL pulse done[owner], increment frame_count, and return to IDLE.
REQ-020 The minimum spacing between consecutive grants SHALL therefore be 4 cycles.
REQ-021 proc_ce SHALL be registered and low in IDLE and DONE, so the processor can never restart on the negedge after busy falls.
REQ-022 proc_* configuration SHALL come from the latched command register and stay constant from ISSUE through DONE.
REQ-023 Requesters SHALL hold req and cmd stable until gnt.
REQ-024 A req that drops before gnt SHALL be treated as withdrawn.
REQ-025 A req that is still high after gnt SHALL be a new request.
REQ-026 Requests arriving outside IDLE SHALL wait and are never lost while held.
REQ-027 Round-robin SHALL be fair: with all requests held, each requester is served once per N frames.
REQ-028 A done pulse and a new req from the same requester in the same cycle SHALL both be honoured.
REQ-029 A requester SHALL receive no second grant before the next IDLE.

Reset
REQ-030 Asserting rst SHALL immediately force: state IDLE, proc_ce=0, gnt=0, done=0, frame_count=0, owner=N-1 (so the first grant starts at requester 0), and the command register to zero.
REQ-031 rst asserted mid-RUN SHALL abort without a done pulse; the processor shares rst and resets too.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the CmdW width function, and the command field offsets, for reuse by requesters and benches.
REQ-033 A single sub-module rr_arbiter SHALL provide a parameterised one-hot round-robin grant, with inputs req and last-owner and outputs a one-hot grant and its index.
REQ-034 The scheduler SHALL contain the FSM, the command register, and frame_count.

Verification
REQ-035 Reset then req=0001 with cmd0 opcode=110 -> gnt=0001 one cycle; proc_ce high until busy falls; proc_opcode=110 throughout; done=0001 once; frame_count=1.
REQ-036 Processor model with W=H=2 (16 pixels) -> proc_ce high for exactly the busy window plus 1 leading cycle, dropped the rising edge after busy falls; no second busy rise.
REQ-037 req=1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3; frame_count=8.
REQ-038 req2 raised during RUN of requester 0 -> req2 waits and is granted in the IDLE following done[0].
REQ-039 rst pulsed mid-RUN of requester 1 -> proc_ce=0 and done=0 immediately, frame_count=0; next grant goes to requester 0.
REQ-040 Requester 3 holds req and changes cmd after gnt -> proc_* keeps the latched values until DONE.
